// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline issue controller: FSM encoding,
// scoreboard age constants, default sizes and the per-source hazard rule.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_HAZ = 2'd1,
    ST_MDW = 2'd2,
    ST_RED = 2'd3
  } sched_state_t;

  // Age of the newest producer of a register: in EX, in MEM, or retired.
  localparam logic [1:0] AGE_EX   = 2'd1;
  localparam logic [1:0] AGE_MEM  = 2'd2;
  localparam logic [1:0] AGE_DONE = 2'd3;

  localparam int NREG_DEFAULT   = 32;
  localparam int MD_LAT_DEFAULT = 32;

  // Branches compare in decode, so they need the value one stage earlier
  // than an ALU consumer: an ALU producer in EX, or a load anywhere before
  // WB, blocks them. ALU consumers only wait on a load still in EX.
  function automatic logic src_hazard(input logic [1:0] age,
                                      input logic       ld,
                                      input logic       is_branch);
    if (is_branch) begin
      return (age == AGE_EX) || (ld && (age == AGE_MEM));
    end
    return ld && (age == AGE_EX);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Occupancy counter for the shared multiply/divide unit. A start pulse loads
// MD_LAT-1; the unit counts as busy during the start cycle and while the
// count is nonzero. 'pending' excludes the start cycle so that the hazard
// logic can use it without a combinational loop through Issue.
module md_busy_counter
  import pipe_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic pending
);

  localparam int W = $clog2(MD_LAT);
  localparam logic [W-1:0] LOAD_VAL = W'(MD_LAT - 1);

  logic [W-1:0] count_q;

  // Load on start, otherwise count down to zero and hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= LOAD_VAL;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign pending = (count_q != '0);
  assign busy    = pending || start;

endmodule

// File: rtl/pipe_hazard_scheduler.sv
// Decode-stage issue controller. One registered scoreboard (age + load flag
// per architectural register) drives load-use stalls, branch stalls and
// branch forwarding from MEM; a busy counter sequences the mul/div unit.
//
// Handshake: IDValid marks a real instruction in decode; Issue is the
// acceptance for that cycle (Issue = IDValid && !Stall). An instruction
// leaves decode only on a cycle where both are high, and only then does it
// update the scoreboard or start the mul/div unit. All combinational
// outputs are low when IDValid is low.
module pipe_hazard_scheduler
  import pipe_pkg::*;
#(
  parameter int NREG   = NREG_DEFAULT,
  parameter int MD_LAT = MD_LAT_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       IDValid,
  input  logic [4:0] IDRs,
  input  logic [4:0] IDRt,
  input  logic       IDUsesRs,
  input  logic       IDUsesRt,
  input  logic [4:0] IDRd,
  input  logic       IDRegWrite,
  input  logic       IDIsLoad,
  input  logic       IDIsBranch,
  input  logic       IDBranchTaken,
  input  logic       IDIsJump,
  input  logic       IDIsMulDiv,
  input  logic       IDReadsHiLo,
  output logic       Issue,
  output logic       Stall,
  output logic       Flush,
  output logic       BranchFwdA,
  output logic       BranchFwdB,
  output logic       MDStart,
  output logic       MDBusy,
  output logic [1:0] State
);

  logic [1:0]   age_q [NREG];
  logic         ld_q  [NREG];
  sched_state_t state_q, state_d;

  logic md_pending;
  logic rs_live, rt_live;
  logic hz_rs, hz_rt, md_hz;
  logic stall_w, issue_w, flush_w, md_start_w;
  logic sb_write;

  // Source hazards, mul/div hazard and the issue decision.
  always_comb begin
    rs_live    = IDUsesRs && (IDRs != 5'd0);
    rt_live    = IDUsesRt && (IDRt != 5'd0);
    hz_rs      = rs_live && src_hazard(age_q[IDRs], ld_q[IDRs], IDIsBranch);
    hz_rt      = rt_live && src_hazard(age_q[IDRt], ld_q[IDRt], IDIsBranch);
    md_hz      = IDValid && md_pending && (IDIsMulDiv || IDReadsHiLo);
    stall_w    = IDValid && (hz_rs || hz_rt || md_hz);
    issue_w    = IDValid && !stall_w;
    flush_w    = issue_w && (IDIsJump || (IDIsBranch && IDBranchTaken));
    md_start_w = issue_w && IDIsMulDiv;
    sb_write   = issue_w && IDRegWrite && (IDRd != 5'd0);
  end

  // Branch operands come from MEM when the newest producer is an ALU op there.
  always_comb begin
    BranchFwdA = IDValid && IDIsBranch && rs_live &&
                 (age_q[IDRs] == AGE_MEM) && !ld_q[IDRs];
    BranchFwdB = IDValid && IDIsBranch && rt_live &&
                 (age_q[IDRt] == AGE_MEM) && !ld_q[IDRt];
  end

  assign Issue   = issue_w;
  assign Stall   = stall_w;
  assign Flush   = flush_w;
  assign MDStart = md_start_w;

  // Scoreboard: an issuing writer restarts its destination at EX, every
  // other pending entry ages by one stage until it retires.
  always_ff @(posedge Clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (Reset) begin
        age_q[r] <= AGE_DONE;
        ld_q[r]  <= 1'b0;
      end else if (sb_write && (IDRd == 5'(r))) begin
        age_q[r] <= AGE_EX;
        ld_q[r]  <= IDIsLoad;
      end else if (age_q[r] != AGE_DONE) begin
        age_q[r] <= age_q[r] + 2'd1;
      end
    end
  end

  md_busy_counter #(
    .MD_LAT(MD_LAT)
  ) u_md_busy (
    .clk    (Clk),
    .reset  (Reset),
    .start  (md_start_w),
    .busy   (MDBusy),
    .pending(md_pending)
  );

  // Next-state: mul/div wait beats data hazard, which beats redirect.
  always_comb begin
    state_d = ST_RUN;
    if (md_hz) begin
      state_d = ST_MDW;
    end else if (stall_w) begin
      state_d = ST_HAZ;
    end else if (flush_w) begin
      state_d = ST_RED;
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_pipe_hazard_scheduler.sv
// Directed bench for pipe_hazard_scheduler. Each test drives one decode
// instruction per cycle, pushes the expected output vector for that cycle
// and compares it at the falling edge.
// Expected vector layout: {State[1:0], Issue, Stall, Flush, FwdA, FwdB,
// MDStart, MDBusy}.
module tb_pipe_hazard_scheduler;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_HAZ = 2'd1;
  localparam logic [1:0] S_MDW = 2'd2;
  localparam logic [1:0] S_RED = 2'd3;

  logic       Clk;
  logic       Reset;
  logic       IDValid;
  logic [4:0] IDRs, IDRt, IDRd;
  logic       IDUsesRs, IDUsesRt, IDRegWrite, IDIsLoad;
  logic       IDIsBranch, IDBranchTaken, IDIsJump, IDIsMulDiv, IDReadsHiLo;
  logic       Issue, Stall, Flush, BranchFwdA, BranchFwdB, MDStart, MDBusy;
  logic [1:0] State;

  logic [8:0] exp_q[$];
  int         checks;
  int         fails;

  pipe_hazard_scheduler #(
    .NREG  (32),
    .MD_LAT(32)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .IDValid      (IDValid),
    .IDRs         (IDRs),
    .IDRt         (IDRt),
    .IDUsesRs     (IDUsesRs),
    .IDUsesRt     (IDUsesRt),
    .IDRd         (IDRd),
    .IDRegWrite   (IDRegWrite),
    .IDIsLoad     (IDIsLoad),
    .IDIsBranch   (IDIsBranch),
    .IDBranchTaken(IDBranchTaken),
    .IDIsJump     (IDIsJump),
    .IDIsMulDiv   (IDIsMulDiv),
    .IDReadsHiLo  (IDReadsHiLo),
    .Issue        (Issue),
    .Stall        (Stall),
    .Flush        (Flush),
    .BranchFwdA   (BranchFwdA),
    .BranchFwdB   (BranchFwdB),
    .MDStart      (MDStart),
    .MDBusy       (MDBusy),
    .State        (State)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout, expected summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- drivers ----------------
  task automatic drv_clear();
    IDValid = 1'b0; IDRs = 5'd0; IDRt = 5'd0; IDRd = 5'd0;
    IDUsesRs = 1'b0; IDUsesRt = 1'b0; IDRegWrite = 1'b0; IDIsLoad = 1'b0;
    IDIsBranch = 1'b0; IDBranchTaken = 1'b0; IDIsJump = 1'b0;
    IDIsMulDiv = 1'b0; IDReadsHiLo = 1'b0;
  endtask

  task automatic drv_alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    drv_clear();
    IDValid = 1'b1; IDRs = rs; IDRt = rt; IDUsesRs = 1'b1; IDUsesRt = 1'b1;
    IDRd = rd; IDRegWrite = 1'b1;
  endtask

  task automatic drv_load(input logic [4:0] rd, input logic [4:0] rs);
    drv_clear();
    IDValid = 1'b1; IDRs = rs; IDUsesRs = 1'b1;
    IDRd = rd; IDRegWrite = 1'b1; IDIsLoad = 1'b1;
  endtask

  task automatic drv_branch(input logic [4:0] rs, input logic [4:0] rt, input logic taken);
    drv_clear();
    IDValid = 1'b1; IDRs = rs; IDRt = rt; IDUsesRs = 1'b1; IDUsesRt = 1'b1;
    IDIsBranch = 1'b1; IDBranchTaken = taken;
  endtask

  task automatic drv_jump();
    drv_clear();
    IDValid = 1'b1; IDIsJump = 1'b1;
  endtask

  task automatic drv_mult(input logic [4:0] rs, input logic [4:0] rt);
    drv_clear();
    IDValid = 1'b1; IDRs = rs; IDRt = rt; IDUsesRs = 1'b1; IDUsesRt = 1'b1;
    IDIsMulDiv = 1'b1;
  endtask

  task automatic drv_mflo(input logic [4:0] rd);
    drv_clear();
    IDValid = 1'b1; IDRd = rd; IDRegWrite = 1'b1; IDReadsHiLo = 1'b1;
  endtask

  task automatic settle(input int n);
    drv_clear();
    repeat (n) @(posedge Clk);
    #1;
  endtask

  function automatic logic [8:0] obs();
    return {State, Issue, Stall, Flush, BranchFwdA, BranchFwdB, MDStart, MDBusy};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [8:0] exp_v, got;
    for (int i = 0; i < 2; i++) begin
      drv_clear();
      exp_q.push_back({S_RUN, 7'b0000000});
      @(negedge Clk);
      got = obs(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL reset step %0d: got %b, expected %b", i, got, exp_v);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_alu_branch();
    logic [8:0] exp_v, got;
    settle(4);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin drv_alu(5'd3, 5'd1, 5'd2);     exp_q.push_back({S_RUN, 7'b1000000}); end
        1: begin drv_branch(5'd3, 5'd4, 1'b0);  exp_q.push_back({S_RUN, 7'b0100000}); end
        2: begin drv_branch(5'd3, 5'd4, 1'b0);  exp_q.push_back({S_HAZ, 7'b1001000}); end
        default: begin drv_clear();             exp_q.push_back({S_RUN, 7'b0000000}); end
      endcase
      @(negedge Clk);
      got = obs(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL alu_branch step %0d: got %b, expected %b", i, got, exp_v);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_load_use();
    logic [8:0] exp_v, got;
    settle(4);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin drv_load(5'd5, 5'd1);          exp_q.push_back({S_RUN, 7'b1000000}); end
        1: begin drv_alu(5'd6, 5'd5, 5'd1);     exp_q.push_back({S_RUN, 7'b0100000}); end
        2: begin drv_alu(5'd6, 5'd5, 5'd1);     exp_q.push_back({S_HAZ, 7'b1000000}); end
        default: begin drv_clear();             exp_q.push_back({S_RUN, 7'b0000000}); end
      endcase
      @(negedge Clk);
      got = obs(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL load_alu step %0d: got %b, expected %b", i, got, exp_v);
      end
      @(posedge Clk); #1;
    end
    settle(4);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin drv_load(5'd5, 5'd1);          exp_q.push_back({S_RUN, 7'b1000000}); end
        1: begin drv_branch(5'd5, 5'd0, 1'b0);  exp_q.push_back({S_RUN, 7'b0100000}); end
        2: begin drv_branch(5'd5, 5'd0, 1'b0);  exp_q.push_back({S_HAZ, 7'b0100000}); end
        3: begin drv_branch(5'd5, 5'd0, 1'b0);  exp_q.push_back({S_HAZ, 7'b1000000}); end
        default: begin drv_clear();             exp_q.push_back({S_RUN, 7'b0000000}); end
      endcase
      @(negedge Clk);
      got = obs(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL load_branch step %0d: got %b, expected %b", i, got, exp_v);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_taken_branch();
    logic [8:0] exp_v, got;
    settle(4);
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: begin drv_branch(5'd1, 5'd2, 1'b1);  exp_q.push_back({S_RUN, 7'b1010000}); end
        1: begin drv_clear();                   exp_q.push_back({S_RED, 7'b0000000}); end
        2: begin drv_jump();                    exp_q.push_back({S_RUN, 7'b1010000}); end
        3: begin drv_clear();                   exp_q.push_back({S_RED, 7'b0000000}); end
        4: begin drv_alu(5'd8, 5'd1, 5'd2);     exp_q.push_back({S_RUN, 7'b1000000}); end
        5: begin drv_branch(5'd8, 5'd2, 1'b1);  exp_q.push_back({S_RUN, 7'b0100000}); end
        6: begin drv_branch(5'd8, 5'd2, 1'b1);  exp_q.push_back({S_HAZ, 7'b1011000}); end
        7: begin drv_clear();                   exp_q.push_back({S_RED, 7'b0000000}); end
        default: begin drv_clear();             exp_q.push_back({S_RUN, 7'b0000000}); end
      endcase
      @(negedge Clk);
      got = obs(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL taken_branch step %0d: got %b, expected %b", i, got, exp_v);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_muldiv();
    logic [8:0] exp_v, got;
    settle(4);
    for (int i = 0; i < 36; i++) begin
      if (i == 0) begin
        drv_mult(5'd1, 5'd2);  exp_q.push_back({S_RUN, 7'b1000011});
      end else if (i <= 31) begin
        drv_mflo(5'd9);        exp_q.push_back({(i == 1) ? S_RUN : S_MDW, 7'b0100001});
      end else if (i == 32) begin
        drv_mflo(5'd9);        exp_q.push_back({S_MDW, 7'b1000000});
      end else if (i == 33) begin
        drv_clear();           exp_q.push_back({S_RUN, 7'b0000000});
      end else if (i == 34) begin
        drv_mult(5'd3, 5'd4);  exp_q.push_back({S_RUN, 7'b1000011});
      end else begin
        drv_mult(5'd5, 5'd6);  exp_q.push_back({S_RUN, 7'b0100001});
      end
      @(negedge Clk);
      got = obs(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL muldiv step %0d: got %b, expected %b", i, got, exp_v);
      end
      @(posedge Clk); #1;
    end
    settle(40);
  endtask

  task automatic test_overwrite_r0();
    logic [8:0] exp_v, got;
    settle(4);
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin drv_load(5'd7, 5'd1);          exp_q.push_back({S_RUN, 7'b1000000}); end
        1: begin drv_alu(5'd7, 5'd1, 5'd2);     exp_q.push_back({S_RUN, 7'b1000000}); end
        2: begin drv_alu(5'd10, 5'd7, 5'd0);    exp_q.push_back({S_RUN, 7'b1000000}); end
        3: begin drv_branch(5'd7, 5'd1, 1'b0);  exp_q.push_back({S_RUN, 7'b1001000}); end
        4: begin drv_load(5'd0, 5'd1);          exp_q.push_back({S_RUN, 7'b1000000}); end
        5: begin drv_branch(5'd0, 5'd0, 1'b0);  exp_q.push_back({S_RUN, 7'b1000000}); end
        default: begin drv_clear();             exp_q.push_back({S_RUN, 7'b0000000}); end
      endcase
      @(negedge Clk);
      got = obs(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL overwrite_r0 step %0d: got %b, expected %b", i, got, exp_v);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp_v, got;
    settle(4);
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin drv_mult(5'd1, 5'd2);          exp_q.push_back({S_RUN, 7'b1000011}); end
        1: begin drv_load(5'd12, 5'd1);         exp_q.push_back({S_RUN, 7'b1000001}); end
        2: begin Reset = 1'b1; drv_clear();     exp_q.push_back({S_RUN, 7'b0000001}); end
        3: begin Reset = 1'b0; drv_branch(5'd12, 5'd1, 1'b0);
                                                exp_q.push_back({S_RUN, 7'b1000000}); end
        4: begin drv_mflo(5'd14);               exp_q.push_back({S_RUN, 7'b1000000}); end
        default: begin drv_clear();             exp_q.push_back({S_RUN, 7'b0000000}); end
      endcase
      @(negedge Clk);
      got = obs(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL reset_mid step %0d: got %b, expected %b", i, got, exp_v);
      end
      @(posedge Clk); #1;
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    checks = 0;
    fails  = 0;
    Reset  = 1'b1;
    drv_clear();
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;

    test_reset();
    test_alu_branch();
    test_load_use();
    test_taken_branch();
    test_muldiv();
    test_overwrite_r0();
    test_reset_mid();

    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_expectations: got %0d queued, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_scheduler.md
# pipe_hazard_scheduler

Scoreboard-based issue controller for the 5-stage pipeline. It sits beside the decode stage and decides each cycle whether the decoded instruction may issue, must stall, or must squash the fetch slot behind a redirect. It also sequences the shared multi-cycle multiply/divide unit. It replaces per-stage ad-hoc hazard comparisons with one registered scoreboard, so branch forwarding and load-use stalls are derived from a single source of truth.

## Interface
Parameters:
- NREG, 32, architectural registers tracked; r0 is never tracked.
- MD_LAT, 32, multiply/divide occupancy in cycles (≥2).

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  synchronous, active-high.
- IDValid  in  1  decode slot holds a real instruction.
- IDRs, IDRt  in  5 each  source register numbers.
- IDUsesRs, IDUsesRt  in  1 each  the instruction reads that source.
- IDRd  in  5  destination register.
- IDRegWrite  in  1  the instruction writes IDRd.
- IDIsLoad  in  1  the instruction is a load.
- IDIsBranch  in  1  beq/bne; compares in decode.
- IDBranchTaken  in  1  the decode comparator resolved taken.
- IDIsJump  in  1  j.
- IDIsMulDiv  in  1  the instruction starts the mul/div unit.
- IDReadsHiLo  in  1  mfhi/mflo.
- Issue  out  1  the instruction leaves decode this cycle.
- Stall  out  1  hold the PC and the IF/ID register.
- Flush  out  1  squash the IF/ID register next edge.
- BranchFwdA, BranchFwdB  out  1 each  decode comparator takes MEMData instead of the register file.
- MDStart  out  1  one-cycle start pulse to the mul/div unit.
- MDBusy  out  1  mul/div occupied.
- State  out  2  FSM state, for debug.

## Operation
- Scoreboard: per register r in 1..NREG-1, Age[r] (2 bits, 0..3) and Ld[r] (1 bit). Age 1 = producer in EX, 2 = in MEM, 3 = retired/no pending. Reset sets every Age to 3 and every Ld to 0.
- Each edge, every Age<3 increments. An issuing writer with IDRd≠0 instead loads Age[IDRd]=1 and Ld[IDRd]=IDIsLoad; issue overrides the increment.
- Per used source s (IDUsesRs/IDRs, IDUsesRt/IDRt, s≠0), hz(s) is:
  - Branch: Age[s]==1, or (Ld[s] && Age[s]==2).
  - Non-branch: Ld[s] && Age[s]==1.
- mdhz = MDBusy && (IDIsMulDiv || IDReadsHiLo).
- Stall = IDValid && (hz(Rs) || hz(Rt) || mdhz). Issue = IDValid && !Stall.
- BranchFwdX = IDIsBranch && Age[src]==2 && !Ld[src].
- Flush = Issue && (IDIsJump || (IDIsBranch && IDBranchTaken)). A branch or jump never flushes while stalled.
- MDStart = Issue && IDIsMulDiv. It loads the busy counter with MD_LAT-1. MDBusy is high while the counter is nonzero or MDStart is high.
- FSM:
  - RUN(0): default state.
  - HAZ(1): stalled on a data hazard.
  - MDW(2): stalled on mdhz.
  - RED(3): the cycle after Flush.
- FSM transitions:
  - Next state is MDW if mdhz.
  - Otherwise HAZ if Stall.
  - Otherwise RED if Flush.
  - Otherwise RUN.
  - MDW has priority over HAZ when both apply.

## Timing
- Stall, Issue, Flush, BranchFwd* and MDStart are combinational from registered state and ID inputs, valid in the same cycle.
- Scoreboard, counter and State update on the rising edge.
- Reset value of every registered output is 0: State=RUN, MDBusy=0. Combinational outputs are 0 whenever IDValid=0.
- Latencies:
  - ALU→branch dependency: 1 stall cycle, then forwarded from MEM.
  - Load→branch: 2 stall cycles, then read from the register file. WB writes on SubClk before the ID read.
  - Load→ALU: 1 stall cycle.
  - ALU→ALU: 0 stall cycles.
- Mul/div dependents stall exactly until the counter reaches 0. A new mul/div may issue on the cycle MDBusy falls.
- Back-to-back writers to the same r: the newest issue wins, and the old entry is overwritten.
- A Reset asserted mid-operation clears the scoreboard and the counter on that edge. MDBusy drops the next cycle.

## Structure
- Shared package `pipe_pkg`: FSM state encoding, Age constants (AGE_EX=1, AGE_MEM=2, AGE_DONE=3), default MD_LAT.
- One sub-module `md_busy_counter`: load, decrement, busy flag. The scoreboard stays inline.

## Test plan
- ALU→branch: add $3 issues, then beq $3,$4 → Stall=1 for 1 cycle, then Issue with BranchFwdA=1, State HAZ→RUN.
- Load-use: lw $5 issues, then add $6,$5,$1 → exactly 1 stall. A following beq $5 instead of the add → 2 stalls, with BranchFwd=0 on issue.
- Taken branch with no hazard → Issue=1, Flush=1 same cycle, State=RED next cycle. Stalled taken branch → Flush only on its issue cycle.
- mult, then mflo with MD_LAT=32 → MDStart pulse, MDBusy high for 32 cycles, mflo stalls until the cycle MDBusy falls, State=MDW throughout.
- Overwrite and r0: lw $7 then add $7 back-to-back → a consumer of $7 sees the ALU rules. Writers to $0 never stall anything.
- Reset during MDBusy and a pending load → the next cycle all Age=3, MDBusy=0, and a dependent instruction issues with no stall.
